// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Also holds the bubble encoding that the pipeline registers load on flush.
package pipe_pkg;

   typedef enum logic [1:0] {
      UPD_HOLD  = 2'b00,
      UPD_ADV   = 2'b01,
      UPD_FLUSH = 2'b10
   } upd_t;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      HALT = 2'b10
   } ctrl_state_t;

   typedef struct packed {
      logic       stop;
      logic       is_load;
      logic [1:0] rw;
      logic [4:0] wait_time;
   } de_ctrl_t;

   // A flushed decode/execute slot never stalls, stops, writes or loads.
   localparam de_ctrl_t BUBBLE = '{stop: 1'b0, is_load: 1'b0, rw: 2'b00, wait_time: 5'd0};

   // Same bank/index rule as the forwarding unit.
   function automatic logic src_match(input logic [1:0] rw, input logic [4:0] rd,
                                      input logic [5:0] src);
      return (rw[1] == src[5]) && (rd == src[4:0]);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Status/control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// PIPE_CTRL_PERF_EN adds the perf_stall/perf_flush counter outputs.
interface pipe_ctrl_if;
   import pipe_pkg::*;

   logic [5:0]  d_rs;
   logic [5:0]  d_rt;
   logic [1:0]  de_rw;
   logic [4:0]  de_rd;
   logic        de_is_load;
   logic [4:0]  de_wait_time;
   logic        de_stop;
   logic        e_redirect;
   upd_t        fd_update;
   upd_t        de_update;
   upd_t        ew_update;
   logic        pc_en;
   logic        halted;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   modport master (
      output d_rs, d_rt, de_rw, de_rd, de_is_load, de_wait_time, de_stop, e_redirect,
      input  fd_update, de_update, ew_update, pc_en, halted
`ifdef PIPE_CTRL_PERF_EN
      , input perf_stall, perf_flush
`endif
   );

   modport slave (
      input  d_rs, d_rt, de_rw, de_rd, de_is_load, de_wait_time, de_stop, e_redirect,
      output fd_update, de_update, ew_update, pc_en, halted
`ifdef PIPE_CTRL_PERF_EN
      , output perf_stall, perf_flush
`endif
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: execute-stage load whose destination matches either decode source.
// Index 0 is deliberately not excluded, so the stall is conservative.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [5:0] d_rs,
   input  logic [5:0] d_rt,
   input  logic [1:0] de_rw,
   input  logic [4:0] de_rd,
   input  logic       de_is_load,
   output logic       load_use
);

   always_comb begin
      load_use = de_is_load && (de_rw != BUBBLE.rw) &&
                 (src_match(de_rw, de_rd, d_rs) || src_match(de_rw, de_rd, d_rt));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the FD/DE/EW pipeline registers and the PC.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/redirect counters.
//
//   state | meaning
//   RUN   | normal issue; execute instruction completes this cycle unless it needs extra cycles
//   WAIT  | multi-cycle execute in progress; cnt extra cycles remain before release
//   HALT  | stop retired; pipeline frozen until rst
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave pif
);

   ctrl_state_t state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        load_use;
   logic        mc_stall;
   logic        redirect_take;

   hazard_detect u_hazard_detect (
      .d_rs       (pif.d_rs),
      .d_rt       (pif.d_rt),
      .de_rw      (pif.de_rw),
      .de_rd      (pif.de_rd),
      .de_is_load (pif.de_is_load),
      .load_use   (load_use)
   );

   // Outside HALT, "complete" is exactly the negation of a multi-cycle stall.
   always_comb begin
      mc_stall = ((state_q == RUN) && (pif.de_wait_time != BUBBLE.wait_time)) ||
                 ((state_q == WAIT) && (cnt_q != 5'd0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == HALT) begin
         state_d = HALT;
      end else if (mc_stall) begin
         if (state_q == RUN) begin
            state_d = WAIT;
            cnt_d   = pif.de_wait_time - 5'd1;
         end else begin
            cnt_d   = cnt_q - 5'd1;
         end
      end else if (pif.de_stop) begin
         state_d = HALT;
         cnt_d   = 5'd0;
      end else begin
         state_d = RUN;
         cnt_d   = 5'd0;
      end
   end

   always_comb begin
      pif.fd_update = UPD_ADV;
      pif.de_update = UPD_ADV;
      pif.ew_update = UPD_ADV;
      pif.pc_en     = 1'b1;
      pif.halted    = 1'b0;
      redirect_take = 1'b0;
      if (rst) begin
         pif.fd_update = UPD_FLUSH;
         pif.de_update = UPD_FLUSH;
         pif.ew_update = UPD_FLUSH;
         pif.pc_en     = 1'b0;
      end else if (state_q == HALT) begin
         pif.fd_update = UPD_HOLD;
         pif.de_update = UPD_HOLD;
         pif.ew_update = UPD_FLUSH;
         pif.pc_en     = 1'b0;
         pif.halted    = 1'b1;
      end else if (mc_stall) begin
         pif.fd_update = UPD_HOLD;
         pif.de_update = UPD_HOLD;
         pif.ew_update = UPD_FLUSH;
         pif.pc_en     = 1'b0;
      end else if (pif.de_stop) begin
         pif.fd_update = UPD_FLUSH;
         pif.de_update = UPD_FLUSH;
         pif.pc_en     = 1'b0;
      end else if (pif.e_redirect) begin
         pif.fd_update = UPD_FLUSH;
         pif.de_update = UPD_FLUSH;
         redirect_take = 1'b1;
      end else if (load_use) begin
         pif.fd_update = UPD_HOLD;
         pif.de_update = UPD_FLUSH;
         pif.pc_en     = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pif.perf_stall <= 32'd0;
         pif.perf_flush <= 32'd0;
      end else begin
         if (!pif.pc_en && (state_q != HALT) && (pif.perf_stall != 32'hffff_ffff))
            pif.perf_stall <= pif.perf_stall + 32'd1;
         if (redirect_take && (pif.perf_flush != 32'hffff_ffff))
            pif.perf_flush <= pif.perf_flush + 32'd1;
      end
   end
`else
   logic unused_redirect;
   always_comb unused_redirect = redirect_take;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, multi-cycle, load-use, redirect, stop.
module tb_pipe_ctrl;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   pipe_ctrl_if pif ();

   pipe_ctrl dut (
      .clk (clk),
      .rst (rst),
      .pif (pif.slave)
   );

   always #5 clk = ~clk;

   // {fd, de, ew, pc_en, halted}
   logic [7:0] obs;
   assign obs = {pif.fd_update, pif.de_update, pif.ew_update, pif.pc_en, pif.halted};

   localparam logic [7:0] O_RST   = 8'b10_10_10_0_0;
   localparam logic [7:0] O_ADV   = 8'b01_01_01_1_0;
   localparam logic [7:0] O_STALL = 8'b00_00_10_0_0;
   localparam logic [7:0] O_LU    = 8'b00_10_01_0_0;
   localparam logic [7:0] O_REDIR = 8'b10_10_01_1_0;
   localparam logic [7:0] O_STOP  = 8'b10_10_01_0_0;
   localparam logic [7:0] O_HALT  = 8'b00_00_10_0_1;

   task automatic idle();
      pif.d_rs = 6'h00; pif.d_rt = 6'h00; pif.de_rw = 2'b00; pif.de_rd = 5'd0;
      pif.de_is_load = 1'b0; pif.de_wait_time = 5'd0; pif.de_stop = 1'b0;
      pif.e_redirect = 1'b0;
   endtask

   // Advance one clock and settle: inputs applied after this are seen before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; idle();
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle();
      tick(); #2;
      total++;
      if (obs !== O_RST) begin bad++; $display("FAIL reset_c1 got=%b want=%b", obs, O_RST); end
      tick(); #2;
      total++;
      if (obs !== O_RST) begin bad++; $display("FAIL reset_c2 got=%b want=%b", obs, O_RST); end
      rst = 1'b0;
      tick(); #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL reset_first_run got=%b want=%b", obs, O_ADV); end
   endtask

   task automatic test_multicycle(input logic [4:0] n);
      do_reset();
      pif.de_wait_time = n;
      for (int i = 0; i < int'(n); i++) begin
         #2;
         total++;
         if (obs !== O_STALL) begin
            bad++; $display("FAIL mc%0d_stall_%0d got=%b want=%b", n, i, obs, O_STALL);
         end
         tick();
      end
      #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL mc%0d_release got=%b want=%b", n, obs, O_ADV); end
      tick(); idle(); #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL mc%0d_after got=%b want=%b", n, obs, O_ADV); end
   endtask

   task automatic test_load_use();
      do_reset();
      pif.de_is_load = 1'b1; pif.de_rw = 2'b01; pif.de_rd = 5'd7; pif.d_rt = 6'h07;
      #2;
      total++;
      if (obs !== O_LU) begin bad++; $display("FAIL lu_stall got=%b want=%b", obs, O_LU); end
      tick(); idle(); #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL lu_next got=%b want=%b", obs, O_ADV); end
      pif.de_is_load = 1'b1; pif.de_rw = 2'b01; pif.de_rd = 5'd7; pif.d_rt = 6'h27;
      #1;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL lu_other_bank got=%b want=%b", obs, O_ADV); end
      pif.d_rt = 6'h00; pif.d_rs = 6'h27; pif.de_rw = 2'b11;
      #1;
      total++;
      if (obs !== O_LU) begin bad++; $display("FAIL lu_rs_bank1 got=%b want=%b", obs, O_LU); end
      pif.de_rw = 2'b00;
      #1;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL lu_no_write got=%b want=%b", obs, O_ADV); end
      idle();
   endtask

   task automatic test_redirect();
      do_reset();
      pif.de_is_load = 1'b1; pif.de_rw = 2'b01; pif.de_rd = 5'd7; pif.d_rt = 6'h07;
      pif.e_redirect = 1'b1;
      #2;
      total++;
      if (obs !== O_REDIR) begin bad++; $display("FAIL redir_over_lu got=%b want=%b", obs, O_REDIR); end
      tick(); idle();
      pif.de_wait_time = 5'd2; pif.e_redirect = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #2;
         total++;
         if (obs !== O_STALL) begin bad++; $display("FAIL redir_wait_%0d got=%b want=%b", i, obs, O_STALL); end
         tick();
      end
      #2;
      total++;
      if (obs !== O_REDIR) begin bad++; $display("FAIL redir_release got=%b want=%b", obs, O_REDIR); end
      tick(); idle(); #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL redir_after got=%b want=%b", obs, O_ADV); end
   endtask

   task automatic test_stop();
      do_reset();
      pif.de_stop = 1'b1;
      #2;
      total++;
      if (obs !== O_STOP) begin bad++; $display("FAIL stop_cycle got=%b want=%b", obs, O_STOP); end
      tick(); idle();
      for (int i = 0; i < 4; i++) begin
         if (i == 2) pif.e_redirect = 1'b1;
         #2;
         total++;
         if (obs !== O_HALT) begin bad++; $display("FAIL halt_%0d got=%b want=%b", i, obs, O_HALT); end
         tick();
      end
      idle(); rst = 1'b1;
      #2;
      total++;
      if (obs !== O_RST) begin bad++; $display("FAIL halt_rst got=%b want=%b", obs, O_RST); end
      tick(); rst = 1'b0; #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL halt_exit got=%b want=%b", obs, O_ADV); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      pif.de_wait_time = 5'd20;
      for (int i = 0; i < 5; i++) tick();
      #2;
      total++;
      if (obs !== O_STALL) begin bad++; $display("FAIL midwait_pre got=%b want=%b", obs, O_STALL); end
      rst = 1'b1; idle();
      tick(); rst = 1'b0; #2;
      total++;
      if (obs !== O_ADV) begin bad++; $display("FAIL midwait_run got=%b want=%b", obs, O_ADV); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_multicycle(5'd3);
      test_multicycle(5'd1);
      test_multicycle(5'd31);
      test_load_use();
      test_redirect();
      test_stop();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
